// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch stage with a 16-word program store, run/halt FSM and stall.
// Define IFETCH_JUMP_EN to make opcode 4'hE an unconditional jump to W[11:8].
module instr_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic          stall,
  output logic [3:0]    opcode,
  output logic [3:0]    operand_1,
  output logic [7:0]    operand_2,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t        state_q;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] pc_q;
  logic [3:0]    opcode_q, operand_1_q;
  logic [7:0]    operand_2_q;
  logic          valid_q, busy_q, done_q;
  logic [15:0]   word;
  logic          is_halt, is_jump;
  assign word    = mem_q[pc_q];
  assign is_halt = word[15:12] == 4'hF;
`ifdef IFETCH_JUMP_EN
  assign is_jump = word[15:12] == 4'hE;
`else
  assign is_jump = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      opcode_q    <= '0;
      operand_1_q <= '0;
      operand_2_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          // A load wins over a simultaneous start
          if (load_en) mem_q[load_addr] <= load_data;
          else if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (is_halt) begin
              state_q <= HALT;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (is_jump) begin
              pc_q    <= word[8 +: AW];
              valid_q <= 1'b0;
            end else begin
              opcode_q    <= word[15:12];
              operand_1_q <= word[11:8];
              operand_2_q <= word[7:0];
              valid_q     <= 1'b1;
              pc_q        <= pc_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign opcode      = opcode_q;
  assign operand_1   = operand_1_q;
  assign operand_2   = operand_2_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench; stimulus queues expected issues, a negedge monitor pops and compares.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  opcode, operand_1;
  logic [7:0]  operand_2;
  logic        instr_valid, busy, done;
  logic [3:0]  pc;
  logic        adv = 1'b0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int op;
    int o1;
    int o2;
    int pc;
  } exp_t;
  exp_t sb[$];

  instr_fetch dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .opcode(opcode),
    .operand_1(operand_1), .operand_2(operand_2), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int op, input int o1, input int o2, input int p);
    exp_t e;
    e.op = op; e.o1 = o1; e.o2 = o2; e.pc = p;
    sb.push_back(e);
  endtask

  // A new instruction is presented only after an edge where RUN was unstalled
  always @(posedge clk) adv <= busy && !stall;

  always @(negedge clk) begin
    if (rst && instr_valid && adv) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got %0h/%0h/%0h expected none", opcode, operand_1, operand_2);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_opcode", opcode, e.op);
        chk("issue_operand_1", operand_1, e.o1);
        chk("issue_operand_2", operand_2, e.o2);
        chk("issue_pc", pc, e.pc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int a, input int d);
    load_en = 1'b1; load_addr = 4'(a); load_data = 16'(d);
    step();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_opcode"}, opcode, 0);
    chk({name, "_operand_1"}, operand_1, 0);
    chk({name, "_operand_2"}, operand_2, 0);
    chk({name, "_valid"}, instr_valid, 0);
    chk({name, "_pc"}, pc, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_reset");
    step();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #3 chk_reset_outputs("reset");
    step();
    rst = 1'b1;
    // Cleared store executes as opcode 0 words
    pulse_start();
    chk("start_busy", busy, 1);
    for (int i = 1; i <= 3; i++) push(0, 0, 0, i);
    repeat (3) step();
    async_reset();
    // Start with load_en high in IDLE: load wins
    load_en = 1'b1; start = 1'b1; load_addr = 4'd0; load_data = 16'h1A05;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("collision_busy", busy, 0);
    chk("collision_done", done, 0);
    load(1, 16'h2B7F);
    load(2, 16'hF000);
    // Straight-line program
    pulse_start();
    push(1, 4'hA, 8'h05, 1);
    push(2, 4'hB, 8'h7F, 2);
    repeat (3) step();
    chk("halt_valid", instr_valid, 0);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 2);
    chk("halt_hold_opcode", opcode, 2);
    // Stall while the first word is presented
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    push(1, 4'hA, 8'h05, 1);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 1);
      chk("stall_valid", instr_valid, 1);
      chk("stall_opcode", opcode, 1);
      chk("stall_operand_2", operand_2, 8'h05);
    end
    stall = 1'b0;
    push(2, 4'hB, 8'h7F, 2);
    step();
    step();
    chk("stall_halt_done", done, 1);
    // Loads during RUN are ignored
    load(2, 16'h3C11);
    load(3, 16'hF000);
    pulse_start();
    push(1, 4'hA, 8'h05, 1);
    step();
    load_en = 1'b1; load_addr = 4'd2; load_data = 16'hF000;
    push(2, 4'hB, 8'h7F, 2);
    step();
    load_en = 1'b0;
    push(3, 4'hC, 8'h11, 3);
    step();
    step();
    chk("runload_done", done, 1);
    chk("runload_pc", pc, 3);
    // Wrap-around with no halt word
    for (int a = 0; a < 16; a++) load(a, 16'h3000);
    pulse_start();
    for (int i = 0; i < 20; i++) push(3, 0, 0, (i + 1) % 16);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("wrap_valid", instr_valid, 1);
    end
    async_reset();
    // Jump program
    load(0, 16'h1000);
    load(1, 16'hE500);
    load(5, 16'hF000);
    pulse_start();
    push(1, 0, 0, 1);
`ifdef IFETCH_JUMP_EN
    step();
    step();
    chk("jump_bubble_valid", instr_valid, 0);
    chk("jump_pc", pc, 5);
    step();
`else
    push(4'hE, 5, 0, 2);
    for (int i = 3; i <= 5; i++) push(0, 0, 0, i);
    repeat (6) step();
`endif
    chk("jump_done", done, 1);
    chk("jump_halt_pc", pc, 5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Program-counter-driven instruction fetch stage that sits directly upstream of the RISC core.
- Holds a 16-word program store loaded through a write port and steps a program counter.
- Presents one decoded instruction per cycle on registered `opcode`/`operand_1`/`operand_2` outputs, which drive the core's inputs of the same names.
- A run/halt state machine, a downstream stall input and an in-band halt opcode control sequencing.

## Interface

Parameters:
- `DEPTH`, 16: number of program words.
- `AW`, 4: program-counter / address width; `DEPTH` = 2^`AW`.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `load_en`  input  1  write `load_data` into program store at `load_addr`.
- `load_addr`  input  AW  program store write address.
- `load_data`  input  16  instruction word: [15:12] opcode, [11:8] operand_1, [7:0] operand_2.
- `start`  input  1  begin execution from address 0.
- `stall`  input  1  downstream not ready; freeze fetch state and outputs.
- `opcode`  output  4  registered opcode to core.
- `operand_1`  output  4  registered operand_1 to core.
- `operand_2`  output  8  registered operand_2 to core.
- `instr_valid`  output  1  outputs hold a new instruction this cycle.
- `pc`  output  AW  address of the next word to fetch.
- `busy`  output  1  high in RUN.
- `done`  output  1  high in HALT.

## Operation

- States: IDLE, RUN, HALT.
- Reset (`rst`=0, async):
  - state = IDLE.
  - `pc`, `opcode`, `operand_1`, `operand_2`, `instr_valid`, `busy`, `done` = 0.
  - All program words cleared to 16'h0000.
- IDLE / HALT:
  - `load_en`=1 writes the program store.
  - `start`=1 with `load_en`=0 → RUN, `pc`<=0, `instr_valid`<=0, `done`<=0.
  - `start` and `load_en` both high: load performed, start ignored.
  - `stall` ignored.
- RUN, `stall`=0, word W = mem[`pc`]:
  - W[15:12] != 4'hF: outputs <= W fields, `instr_valid`<=1, `pc`<=`pc`+1.
  - W[15:12] == 4'hF (halt): no issue; `instr_valid`<=0, outputs hold previous values, `pc` unchanged, → HALT.
- RUN, `stall`=1: `pc`, outputs, `instr_valid` and state all hold.
- `load_en` in RUN is ignored; program store is not modified.
- `pc` wraps from `DEPTH`-1 to 0 with no flag; a program without a halt runs forever.
- `busy` = (state==RUN); `done` = (state==HALT). Both are registered with the state.

## Timing

- Start latency:
  - Edge N samples `start` → state RUN at N.
  - Edge N+1 fetches mem[0] → `instr_valid`=1 after N+1.
- Throughput: one instruction per unstalled cycle.
- `instr_valid` is a per-cycle pulse per fetched word; back-to-back words keep it high continuously.
- Halt: the edge that reads the halt word drops `instr_valid` and raises `done` together.
- Stall takes effect on the same edge it is sampled. The instruction on the outputs stays presented with `instr_valid` unchanged until `stall` falls.
- Reset mid-RUN: immediate return to reset values regardless of `clk`; any partially issued instruction is discarded.

## Configuration

- `IFETCH_JUMP_EN` defined: opcode 4'hE is an unconditional jump.
  - In RUN, unstalled, W[15:12]==4'hE → `pc`<=W[11:8] (low AW bits), `instr_valid`<=0, outputs hold.
  - The jump word is not issued to the core.
- `IFETCH_JUMP_EN` undefined: 4'hE is fetched and issued like any other non-halt opcode.

## Test plan

- Reset: drive `rst`=0 asynchronously mid-cycle → all outputs 0, `done`=0, `busy`=0 immediately; after release, mem[0..15] read back via execution as 16'h0000.
- Straight-line program: load 16'h1A05, 16'h2B7F, 16'hF000 at addresses 0–2, pulse `start`:
  - Edge+2: opcode=1, operand_1=A, operand_2=05, `instr_valid`=1.
  - Next edge: 2/B/7F.
  - Next edge: `instr_valid`=0, `done`=1, `pc`=2.
- Stall: same program, assert `stall` for 3 cycles while 1/A/05 is presented → outputs, `pc`=1 and `instr_valid`=1 held for 3 cycles, then 2/B/7F on the first unstalled edge.
- Wrap-around: load 16'h3000 in all 16 words, start, run 20 cycles → `pc` sequence 0…15,0,1,2,3 and `instr_valid` continuously 1.
- Load/start collision and RUN-load: assert `start` with `load_en` in IDLE → state stays IDLE. In RUN, write 16'hF000 to the next address → ignored, execution continues.
- Jump with `IFETCH_JUMP_EN`: mem[0]=16'h1000, mem[1]=16'hE500, mem[5]=16'hF000 → one issue (opcode 1), one bubble, then HALT with `pc`=5. Without the macro → opcode E issued as the second instruction.
